// File: rtl/patch_streamer_if.sv
// patch_streamer_if: bundles the picture-buffer side (patch array, fetch
// handshake) and the pixel-stream side (valid/ready, RGB, framing flags)
// of the patch streamer.
// Optional macro PATCH_STREAMER_LUMA_EN adds the o_Y luma lane.
// master: the streamer itself. slave: the environment around it.
interface patch_streamer_if #(
    parameter int DW  = 10,
    parameter int DIM = 16
);
    logic          i_oktofetch;
    logic [DW-1:0] i_buf [0:2][0:DIM-1][0:DIM-1];
    logic          o_fetch;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_R;
    logic [DW-1:0] o_G;
    logic [DW-1:0] o_B;
    logic          o_sof;
    logic          o_eol;
    logic          o_eof;
    logic [15:0]   o_frames;
`ifdef PATCH_STREAMER_LUMA_EN
    logic [DW-1:0] o_Y;
`endif

`ifdef PATCH_STREAMER_LUMA_EN
    modport master (
        input  i_oktofetch, i_buf, i_ready,
        output o_fetch, o_valid, o_R, o_G, o_B, o_sof, o_eol, o_eof, o_frames, o_Y
    );
    modport slave (
        output i_oktofetch, i_buf, i_ready,
        input  o_fetch, o_valid, o_R, o_G, o_B, o_sof, o_eol, o_eof, o_frames, o_Y
    );
`else
    modport master (
        input  i_oktofetch, i_buf, i_ready,
        output o_fetch, o_valid, o_R, o_G, o_B, o_sof, o_eol, o_eof, o_frames
    );
    modport slave (
        output i_oktofetch, i_buf, i_ready,
        input  o_fetch, o_valid, o_R, o_G, o_B, o_sof, o_eol, o_eof, o_frames
    );
`endif
endinterface

// File: rtl/patch_streamer.sv
// patch_streamer: waits for a full patch from the picture buffer, snapshots
// the whole parallel array in one edge, acknowledges with a one-cycle fetch
// pulse, then streams the snapshot in raster order over valid/ready.
// Because the data comes from the private snapshot, the buffer is free to
// refill while a patch is being streamed.
// Optional macro PATCH_STREAMER_LUMA_EN adds o_Y = (R + 2G + B) >> 2.
module patch_streamer #(
    parameter int DW  = 10,
    parameter int DIM = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    patch_streamer_if.master bus
);

    localparam int AW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [AW-1:0] LAST = AW'(DIM - 1);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t        state;
    logic [AW-1:0] h_cnt;
    logic [AW-1:0] v_cnt;
    logic          fetch_reg;
    logic          valid_reg;
    logic [15:0]   frame_count;

    logic [DW-1:0] snap [0:2][0:DIM-1][0:DIM-1];

    logic          capture;
    logic          accept;
    logic          at_last_col;
    logic          at_last_row;
    logic [DW-1:0] pix_r;
    logic [DW-1:0] pix_g;
    logic [DW-1:0] pix_b;

    assign capture     = (state == S_IDLE) && bus.i_oktofetch;
    assign accept      = valid_reg && bus.i_ready;
    assign at_last_col = (h_cnt == LAST);
    assign at_last_row = (v_cnt == LAST);

    // Snapshot is loaded only on the idle capture edge and is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (capture && !i_rst) begin
            snap <= bus.i_buf;
        end
    end

    // Control FSM: capture handshake, raster counters, frame counter, registered valid/fetch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            h_cnt       <= '0;
            v_cnt       <= '0;
            fetch_reg   <= 1'b0;
            valid_reg   <= 1'b0;
            frame_count <= '0;
        end else begin
            fetch_reg <= 1'b0;
            case (state)
                S_IDLE: begin
                    valid_reg <= 1'b0;
                    if (bus.i_oktofetch) begin
                        h_cnt     <= '0;
                        v_cnt     <= '0;
                        fetch_reg <= 1'b1;
                        valid_reg <= 1'b1;
                        state     <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (accept) begin
                        h_cnt <= h_cnt + AW'(1);
                        if (at_last_col) begin
                            v_cnt <= v_cnt + AW'(1);
                            if (at_last_row) begin
                                frame_count <= frame_count + 16'd1;
                                valid_reg   <= 1'b0;
                                state       <= S_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign pix_r = snap[0][v_cnt][h_cnt];
    assign pix_g = snap[1][v_cnt][h_cnt];
    assign pix_b = snap[2][v_cnt][h_cnt];

    assign bus.o_fetch  = fetch_reg;
    assign bus.o_valid  = valid_reg;
    assign bus.o_frames = frame_count;
    assign bus.o_R      = valid_reg ? pix_r : '0;
    assign bus.o_G      = valid_reg ? pix_g : '0;
    assign bus.o_B      = valid_reg ? pix_b : '0;
    assign bus.o_sof    = valid_reg && (h_cnt == '0) && (v_cnt == '0);
    assign bus.o_eol    = valid_reg && at_last_col;
    assign bus.o_eof    = valid_reg && at_last_col && at_last_row;

`ifdef PATCH_STREAMER_LUMA_EN
    // Sum is two bits wider than a channel so R + 2G + B can never overflow.
    logic [DW+1:0] luma_sum;
    assign luma_sum  = {2'b00, pix_r} + {1'b0, pix_g, 1'b0} + {2'b00, pix_b};
    assign bus.o_Y   = valid_reg ? luma_sum[DW+1:2] : '0;
`endif

endmodule

// File: doc/patch_streamer.md
# patch_streamer

Read-side consumer of the 16x16 RGB picture buffer. Waits for a full patch (`i_oktofetch`), snapshots the whole parallel patch array, and acknowledges with a one-cycle `o_fetch` pulse. It then streams the snapshot pixel-by-pixel in raster order over a valid/ready handshake to the downstream tracking datapath. Sits between the picture buffer and the feature/tracking logic.

## Interface
- `DW`, 10, pixel channel width in bits.
- `DIM`, 16, patch side length; must be a power of two ≥ 2; counters are log2(DIM) bits.
- `i_clk`  in  1  single clock; all state changes on its rising edge.
- `i_rst`  in  1  reset; one clock, reset is synchronous and active-high.
- `i_oktofetch`  in  1  a full patch is present on `i_buf`.
- `i_buf`  in  DW × [0:2][0:DIM-1][0:DIM-1]  parallel patch; index order [channel R/G/B][row V][column H].
- `o_fetch`  out  1  one-cycle acknowledge; the buffer releases the patch on it.
- `o_valid`  out  1  pixel outputs valid.
- `i_ready`  in  1  downstream accepts the pixel this cycle.
- `o_R`, `o_G`, `o_B`  out  DW each  current pixel.
- `o_sof`  out  1  current pixel is (V=0,H=0).
- `o_eol`  out  1  current pixel is H=DIM-1.
- `o_eof`  out  1  current pixel is (V=DIM-1,H=DIM-1).
- `o_frames`  out  16  count of completely streamed patches; wraps 0xFFFF→0.

## Operation
- FSM states:
  - S_IDLE: `o_valid`=0. If `i_oktofetch`=1, then at the edge:
    - capture all 3·DIM·DIM words of `i_buf` into the snapshot;
    - set H=V=0;
    - register `o_fetch`=1;
    - go to S_STREAM.
  - S_STREAM: `o_valid`=1, `o_R/G/B` = snapshot[·][V][H].
    - On `o_valid`&&`i_ready`, H increments.
    - H=DIM-1 wraps to 0 and V increments.
    - Accept at V=H=DIM-1: `o_frames`+1, go to S_IDLE.
- `i_oktofetch` is ignored outside S_IDLE.
- The snapshot is never written outside the S_IDLE capture edge. The buffer may refill or overwrite while streaming without corrupting output.
- `o_fetch` is asserted for exactly one cycle per capture, never without a preceding `i_oktofetch`=1 sample.
- `o_R/G/B`, `o_sof`, `o_eol`, `o_eof` are forced to 0 whenever `o_valid`=0.
- Handshake: while `o_valid`=1 and `i_ready`=0, all pixel outputs and flags hold stable. `o_valid` never drops mid-patch.
- Reset values: state S_IDLE, H=V=0, `o_fetch`=0, `o_valid`=0, `o_R/G/B`=0, flags 0, `o_frames`=0. The snapshot contents are not reset.
- Reset mid-stream: the patch is abandoned, `o_frames` is cleared, and no further `o_fetch` occurs until a new `i_oktofetch` is sampled in S_IDLE.

## Timing
- Capture latency: `i_oktofetch`=1 sampled at edge t → `o_fetch`=1 and `o_valid`=1 with the (0,0) pixel during cycle t+1.
- Throughput: with `i_ready` held 1, one pixel per cycle. A patch takes DIM·DIM cycles (256 at default).
- Turnaround: the final accept at edge e returns to S_IDLE. The earliest next capture is at edge e+1, so there is a minimum of one idle cycle (`o_valid`=0) between patches.
- `o_frames` updates on the same edge as the final accept.
- `o_sof`/`o_eol`/`o_eof` are decoded from the registered H/V, so they are valid in the same cycle as their pixel.

## Configuration
- `PATCH_STREAMER_LUMA_EN`:
  - Defined: adds output `o_Y` (DW bits) = (R + 2·G + B) >> 2 of the current pixel.
    - Computed at DW+2 bits, then truncated; no overflow.
    - Combinational from the snapshot; same cycle as `o_R/G/B`.
    - 0 when `o_valid`=0.
  - Undefined: `o_Y` port and its adder are absent; all other behaviour is identical.

## Test plan
- Reset, then `i_oktofetch`=1 with pixel[c][v][h] = c·256 + v·16 + h, `i_ready`=1:
  - `o_fetch` pulses once;
  - 256 consecutive valid pixels in raster order;
  - `o_sof` on the first, `o_eol` every 16th, `o_eof` on the 256th;
  - `o_frames`=1.
- Backpressure: `i_ready` toggles pseudo-randomly. No pixel is lost or duplicated, and outputs are stable during stalls.
- Change `i_buf` to all 0x3FF one cycle after capture. The streamed data still matches the captured pattern.
- Hold `i_oktofetch`=1 continuously for 3 patches:
  - exactly 3 `o_fetch` pulses;
  - each pulse is followed by exactly one idle cycle after that patch's final accept;
  - `o_frames`=3.
- Assert `i_rst` at pixel 100 of a patch. All outputs read 0 the next cycle, and a fresh capture restarts at (0,0).
- With `PATCH_STREAMER_LUMA_EN`: R=0x3FF, G=0x3FF, B=0x3FF → `o_Y`=0x3FF; R=4, G=2, B=0 → `o_Y`=2.
